// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the default byte width and the transmit-FIFO state encoding.
package uart_pkg;

    localparam int PACK_SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART transmit FIFO.
// One synchronous write port, one asynchronous read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (combinational from rd_addr)
module uart_fifo_mem #(
    parameter int PACK_SIZE = 8,
    parameter int DEPTH     = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [PACK_SIZE-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [PACK_SIZE-1:0] rd_data
);

    logic [PACK_SIZE-1:0] mem [DEPTH];

    // No reset on the array: contents are only meaningful behind count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter, with the request/busy
// handshake that hands one byte at a time to the shifter.
//   clk, rst        : clock, synchronous active-high reset
//   wr_valid/wr_data/wr_ready : producer side, write when valid && !full
//   tx_byte_valid/tx_byte_data: request to the transmitter
//   tx_active, tx_done        : transmitter busy level, end-of-byte pulse
//   count, empty, full        : occupancy (registered)
//   overflow                  : sticky, a write was offered while full
//
// state  | meaning
// S_IDLE | no byte in flight; pops the head entry when not empty
// S_REQ  | tx_byte_valid held high until the transmitter reports active
// S_BUSY | transmitter shifting; wait for tx_done
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int PACK_SIZE = PACK_SIZE_DEFAULT,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [PACK_SIZE-1:0]   wr_data,
    output logic                   wr_ready,
    output logic                   tx_byte_valid,
    output logic [PACK_SIZE-1:0]   tx_byte_data,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    tx_fifo_state_t state_q, state_d;

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [PACK_SIZE-1:0] head_data;
    logic                 wr_en;
    logic                 pop;

    // Flags come from registered count only, so wr_ready never depends on
    // a same-cycle pop and a write into a full FIFO is always refused.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign wr_en    = wr_valid && !full;

    assign tx_byte_valid = (state_q == S_REQ);

    uart_fifo_mem #(
        .PACK_SIZE (PACK_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (tx_active) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            tx_byte_data <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                tx_byte_data <= head_data;
            end
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int PACK_SIZE    = 8;
    localparam int DEPTH        = 16;
    localparam int CLK_PER_BIT  = 10;
    localparam int FRAME_CYCLES = CLK_PER_BIT * 10;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_byte_valid;
    logic [7:0] tx_byte_data;
    logic       tx_active;
    logic       tx_done;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    // Transmitter stand-in: automatic serialiser, or manual control by the script.
    logic tx_auto;
    logic auto_active, auto_done;
    logic man_active, man_done;

    assign tx_active = tx_auto ? auto_active : man_active;
    assign tx_done   = tx_auto ? auto_done   : man_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];

    uart_tx_fifo #(
        .PACK_SIZE (PACK_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_data  (tx_byte_data),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serialiser model: accepts a request, is busy for one 10-bit frame at
    // CLK_PER_BIT clocks per bit, then pulses done; the byte counts as received.
    initial begin
        auto_active = 1'b0;
        auto_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            auto_done = 1'b0;
            if (tx_auto && tx_byte_valid && !auto_active) begin
                rx_q.push_back(tx_byte_data);
                auto_active = 1'b1;
                for (int i = 0; i < FRAME_CYCLES - 1; i++) begin
                    @(posedge clk);
                    #1;
                end
                auto_active = 1'b0;
                auto_done   = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (rx_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic wait_frame_end();
        int cyc;
        cyc = 0;
        while ((auto_active || auto_done) && cyc < 2 * FRAME_CYCLES) begin
            step();
            cyc++;
        end
        check("frame_end", {30'd0, auto_active, auto_done}, 32'd0);
        step();
        step();
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check(tag, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] h;
        logic [7:0] s1;
        int n;
        int gap;
        int hold;

        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = '0;
        tx_auto    = 1'b1;
        man_active = 1'b0;
        man_done   = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_valid", tx_byte_valid, 0);
        check("rst_data", tx_byte_data, 0);
        check("rst_overflow", overflow, 0);

        // Single byte, with the two-cycle write-to-request latency
        write_byte(8'hA5);
        exp_q.push_back(8'hA5);
        check("lat_valid_c1", tx_byte_valid, 0);
        check("lat_count_c1", count, 1);
        step();
        check("lat_valid_c2", tx_byte_valid, 1);
        check("lat_data_c2", tx_byte_data, 8'hA5);
        check("lat_count_c2", count, 0);
        wait_rx(1, 2 * FRAME_CYCLES);
        compare_streams("single_rx");
        wait_frame_end();
        check("single_empty", empty, 1);
        check("single_valid", tx_byte_valid, 0);

        // Random bytes with random gaps, never more than the FIFO can hold
        n = int'($urandom_range(6, 12));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
            gap = int'($urandom_range(0, 3));
            repeat (gap) step();
        end
        wait_rx(n, (n + 1) * (FRAME_CYCLES + 4));
        compare_streams("rand_rx");
        wait_frame_end();
        check("rand_empty", empty, 1);

        // Handshake: request held while the transmitter stays inactive
        tx_auto    = 1'b0;
        man_active = 1'b0;
        h = 8'($urandom);
        write_byte(h);
        step();
        check("hs_valid", tx_byte_valid, 1);
        check("hs_data", tx_byte_data, h);
        hold = int'($urandom_range(3, 8));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hs_hold_valid", tx_byte_valid, 1);
            check("hs_hold_data", tx_byte_data, h);
        end
        man_active = 1'b1;
        step();
        check("hs_valid_drop", tx_byte_valid, 0);
        check("hs_data_kept", tx_byte_data, h);

        // Burst of 16 while the transmitter is busy, then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            b = 8'(i);
            exp_q.push_back(b);
            write_byte(b);
        end
        check("burst_full", full, 1);
        check("burst_count", count, DEPTH);
        check("burst_wr_ready", wr_ready, 0);
        check("burst_no_ovf", overflow, 0);
        write_byte(8'hFF);
        check("ovf_flag", overflow, 1);
        check("ovf_wr_ready", wr_ready, 0);
        check("ovf_count", count, DEPTH);

        // Release; the pop cycle while full must still refuse a write
        man_done   = 1'b1;
        man_active = 1'b0;
        step();
        man_done = 1'b0;
        check("rel_idle_valid", tx_byte_valid, 0);
        write_byte(8'hEE);
        check("popfull_count", count, DEPTH - 1);
        check("popfull_valid", tx_byte_valid, 1);
        check("popfull_data", tx_byte_data, 8'h01);
        rx_q.push_back(tx_byte_data);
        man_active = 1'b1;
        step();
        man_done   = 1'b1;
        man_active = 1'b0;
        step();
        man_done = 1'b0;
        tx_auto  = 1'b1;
        wait_rx(DEPTH, DEPTH * (FRAME_CYCLES + 4));
        compare_streams("burst_rx");
        wait_frame_end();
        check("burst_empty", empty, 1);
        check("ovf_sticky", overflow, 1);

        // Simultaneous write and pop at count 3
        tx_auto    = 1'b0;
        man_active = 1'b0;
        man_done   = 1'b0;
        write_byte(8'($urandom));
        step();
        check("sim_req", tx_byte_valid, 1);
        man_active = 1'b1;
        step();
        s1 = 8'($urandom);
        write_byte(s1);
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        check("sim_count_pre", count, 3);
        man_done   = 1'b1;
        man_active = 1'b0;
        step();
        man_done = 1'b0;
        check("sim_idle_count", count, 3);
        check("sim_idle_valid", tx_byte_valid, 0);
        write_byte(8'($urandom));
        check("sim_count_post", count, 3);
        check("sim_valid", tx_byte_valid, 1);
        check("sim_data", tx_byte_data, s1);

        // Reset while busy with 5 bytes queued
        man_active = 1'b1;
        step();
        check("busy_valid", tx_byte_valid, 0);
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        check("busy_count", count, 5);
        check("busy_ovf", overflow, 1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        man_active = 1'b0;
        check("mrst_count", count, 0);
        check("mrst_empty", empty, 1);
        check("mrst_full", full, 0);
        check("mrst_wr_ready", wr_ready, 1);
        check("mrst_valid", tx_byte_valid, 0);
        check("mrst_data", tx_byte_data, 0);
        check("mrst_overflow", overflow, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mrst_quiet_valid", tx_byte_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
